// File: rtl/mcdp_pkg.sv
// Shared encodings for the multi-cycle datapath: opcodes, functs, FSM states, ALU ops.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package mcdp_pkg;

  // Major opcodes, IR[15:12]
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_LW    = 4'b0101;
  localparam logic [3:0] OP_SW    = 4'b0110;
  localparam logic [3:0] OP_BEQ   = 4'b0111;
  localparam logic [3:0] OP_BNE   = 4'b1000;
  localparam logic [3:0] OP_J     = 4'b1001;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // R-type function codes, IR[1:0]
  localparam logic [1:0] FN_ADD = 2'b00;
  localparam logic [1:0] FN_SUB = 2'b01;
  localparam logic [1:0] FN_AND = 2'b10;
  localparam logic [1:0] FN_OR  = 2'b11;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  // Map an R-type funct field onto the ALU operation it selects.
  function automatic alu_op_e funct_to_alu_op(input logic [1:0] funct);
    alu_op_e op;
    case (funct)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mcdp_alu.sv
// Combinational ALU: ADD/SUB/AND/OR on DATA_W operands plus an a==b compare for branches.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; result follows the inputs.
module mcdp_alu
  import mcdp_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] y,
  output logic              eq
);

  // Select the arithmetic/logic result; arithmetic wraps at DATA_W bits.
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      default: y = '0;
    endcase
  end

  assign eq = (a == b);

endmodule

// File: rtl/mcdp_multicycle_datapath.sv
// Multi-cycle datapath with internal FSM controller and one shared memory port; MCDP_JUMP_EN builds J.
// Latency: 2 (illegal) to 5 (LW) cycles per instruction, plus one cycle per memory wait cycle.
// Backpressure: mem_req/we/addr/wdata come from state registers and hold until mem_ready completes.
module mcdp_multicycle_datapath
  import mcdp_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 16,
  parameter int unsigned PC_RESET = 10
) (
  input  logic              Clock,
  input  logic              Resetn,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        opcode
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(PC_RESET);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q;
  logic [15:0]         ir_q;
  logic [DATA_W-1:0]   a_q, b_q, alu_out_q, mdr_q;
  logic [DATA_W-1:0]   regs_q [4];
  logic                halted_q, illegal_q;
  // Low for the reset cycles so mem_req drops on the reset edge, high from the first edge after release.
  logic                run_q;

  // Instruction fields
  logic [3:0]          ir_op;
  logic [1:0]          rs, rt, rd, funct;
  logic [DATA_W-1:0]   imm_ext;
  logic [ADDR_W-1:0]   br_off, pc_plus2, br_tgt, eff_addr;
  logic                op_legal;

  // ALU hookup
  logic [DATA_W-1:0]   alu_b, alu_y;
  alu_op_e             alu_op;
  logic                alu_eq;
  logic                acc_done;
  logic [1:0]          wb_dst;
  logic [DATA_W-1:0]   wb_data;

  assign ir_op    = ir_q[15:12];
  assign rs       = ir_q[11:10];
  assign rt       = ir_q[9:8];
  assign rd       = ir_q[7:6];
  assign funct    = ir_q[1:0];
  assign imm_ext  = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
  assign br_off   = {{(ADDR_W-9){ir_q[7]}}, ir_q[7:0], 1'b0};
  assign pc_plus2 = pc_q + ADDR_W'(2);
  // pc_q already holds PC+2 of the branch when EXEC runs.
  assign br_tgt   = pc_q + br_off;
  assign eff_addr = ADDR_W'(alu_out_q);

  assign wb_dst   = (ir_op == OP_RTYPE) ? rd : rt;
  assign wb_data  = (ir_op == OP_LW) ? mdr_q : alu_out_q;

  // Decide which opcodes the core executes; anything else flags illegal and acts as a NOP.
  always_comb begin
    op_legal = 1'b0;
    case (ir_op)
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW,
      OP_BEQ, OP_BNE, OP_HALT: op_legal = 1'b1;
`ifdef MCDP_JUMP_EN
      OP_J:                    op_legal = 1'b1;
`endif
      default:                 op_legal = 1'b0;
    endcase
  end

`ifdef MCDP_JUMP_EN
  logic [ADDR_W-1:0] jmp_tgt;
  // Keep the region bits of PC+2 above bit 12, replace the rest with the word offset from IR.
  assign jmp_tgt = (pc_q & ~ADDR_W'(13'h1FFF)) | ADDR_W'({ir_q[11:0], 1'b0});
`endif

  // Branches compare rs/rt, R-type uses rt, everything else adds the immediate.
  assign alu_b  = (ir_op == OP_RTYPE || ir_op == OP_BEQ || ir_op == OP_BNE) ? b_q : imm_ext;
  assign alu_op = (ir_op == OP_RTYPE) ? funct_to_alu_op(funct) : ALU_ADD;

  mcdp_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a  (a_q),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y),
    .eq (alu_eq)
  );

  assign acc_done = mem_req & mem_ready;

  // FSM state register.
  always_ff @(posedge Clock) begin
    if (!Resetn) state_q <= FETCH;
    else         state_q <= state_d;
  end

  // Next state and memory port drive, derived only from state and registers (never from mem_ready).
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = '0;
    case (state_q)
      FETCH: begin
        mem_req = run_q;
        if (run_q && mem_ready) state_d = DECODE;
      end
      DECODE: begin
        if (!op_legal)              state_d = FETCH;
        else if (ir_op == OP_HALT)  state_d = HALTED;
        else                        state_d = EXEC;
      end
      EXEC: begin
        if (ir_op == OP_LW || ir_op == OP_SW)           state_d = MEM;
        else if (ir_op == OP_RTYPE || ir_op == OP_ADDI) state_d = WB;
        else                                            state_d = FETCH;
      end
      MEM: begin
        mem_req  = run_q;
        mem_addr = eff_addr;
        if (ir_op == OP_SW) begin
          mem_we    = 1'b1;
          mem_wdata = b_q;
        end
        if (run_q && mem_ready) state_d = (ir_op == OP_SW) ? FETCH : WB;
      end
      WB:      state_d = FETCH;
      HALTED:  state_d = HALTED;
      default: state_d = FETCH;
    endcase
  end

  // Datapath registers: IR/PC on fetch, operands on decode, ALU result and PC redirect on exec, MDR, writeback.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      pc_q      <= PC_INIT;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      run_q     <= 1'b0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        FETCH: begin
          if (acc_done) begin
            ir_q <= mem_rdata[15:0];
            pc_q <= pc_plus2;
          end
        end
        DECODE: begin
          a_q <= regs_q[rs];
          b_q <= regs_q[rt];
          if (!op_legal)             illegal_q <= 1'b1;
          else if (ir_op == OP_HALT) halted_q  <= 1'b1;
        end
        EXEC: begin
          alu_out_q <= alu_y;
          if ((ir_op == OP_BEQ && alu_eq) || (ir_op == OP_BNE && !alu_eq)) pc_q <= br_tgt;
`ifdef MCDP_JUMP_EN
          if (ir_op == OP_J) pc_q <= jmp_tgt;
`endif
        end
        MEM: begin
          if (acc_done && ir_op == OP_LW) mdr_q <= mem_rdata;
        end
        WB: begin
          regs_q[wb_dst] <= wb_data;
        end
        default: ;
      endcase
    end
  end

  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign pc      = pc_q;
  assign opcode  = ir_q[15:12];

endmodule

// File: tb/tb_mcdp_multicycle_datapath.sv
// Directed bench for mcdp_multicycle_datapath with a wait-state memory model and access log.
// Latency: each program runs to HALT; access timestamps give per-instruction cycle counts.
// Backpressure: memory inserts fetch_wait/data_wait cycles and watches request stability.
module tb_mcdp_multicycle_datapath;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        mem_req, mem_we, halted, illegal;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_addr, mem_wdata, pc;
  logic [15:0] mem_rdata = '0;
  logic [3:0]  opcode;

  always #5 Clock = ~Clock;

  mcdp_multicycle_datapath #(
    .DATA_W   (16),
    .ADDR_W   (16),
    .PC_RESET (10)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .halted    (halted),
    .illegal   (illegal),
    .pc        (pc),
    .opcode    (opcode)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mem [256];
  int          fetch_wait = 0;
  int          data_wait  = 0;
  int          cyc = 0;
  int          wait_cnt = 0;
  bit          prev_wait = 1'b0;
  logic [15:0] p_addr, p_wdata;
  logic        p_we;
  int          stab_err = 0;

  logic [15:0] acc_addr[$];
  logic [15:0] acc_wdata[$];
  logic        acc_we[$];
  int          acc_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model, evaluated on the falling edge; the access completes on the following rising edge.
  always @(negedge Clock) begin
    int cfg;
    cyc++;
    if (mem_req === 1'b1) begin
      if (prev_wait && (mem_addr !== p_addr || mem_we !== p_we || (mem_we && mem_wdata !== p_wdata)))
        stab_err++;
      cfg = (mem_addr >= 16'h0020) ? data_wait : fetch_wait;
      mem_rdata = mem[mem_addr[8:1]];
      if (wait_cnt >= cfg) begin
        mem_ready = 1'b1;
        wait_cnt  = 0;
        prev_wait = 1'b0;
        acc_addr.push_back(mem_addr);
        acc_we.push_back(mem_we);
        acc_wdata.push_back(mem_wdata);
        acc_cyc.push_back(cyc);
      end else begin
        mem_ready = 1'b0;
        wait_cnt++;
        prev_wait = 1'b1;
        p_addr    = mem_addr;
        p_we      = mem_we;
        p_wdata   = mem_wdata;
      end
    end else begin
      if (prev_wait && Resetn) stab_err++;
      mem_ready = 1'b0;
      wait_cnt  = 0;
      prev_wait = 1'b0;
    end
  end

  task automatic put(input logic [15:0] addr, input logic [15:0] data);
    mem[addr[8:1]] = data;
  endtask

  // Unused memory holds HALT so a misdirected PC stops the run instead of wandering.
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic enter_reset();
    @(negedge Clock);
    Resetn = 1'b0;
    repeat (2) @(negedge Clock);
  endtask

  task automatic release_reset(output int base);
    base   = acc_addr.size();
    Resetn = 1'b1;
  endtask

  task automatic run_until_halt(input string tag, input int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge Clock);
      n++;
    end
    chk({tag, "_halted"}, halted, 1);
  endtask

  task automatic chk_acc(input string tag, input int base, input int k,
                         input logic [15:0] a, input logic we, input logic [15:0] wd);
    int idx = base + k;
    chk({tag, "_seen"}, acc_addr.size() > idx, 1);
    if (acc_addr.size() > idx) begin
      chk({tag, "_addr"}, acc_addr[idx], a);
      chk({tag, "_we"}, acc_we[idx], we);
      if (we) chk({tag, "_wdata"}, acc_wdata[idx], wd);
    end
  endtask

  task automatic chk_gap(input string tag, input int base, input int i, input int j, input int exp);
    chk({tag, "_seen"}, acc_addr.size() > base + j, 1);
    if (acc_addr.size() > base + j) chk(tag, acc_cyc[base + j] - acc_cyc[base + i], exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int bad;
    int n;

    // ---------------- Program 1: reset, arithmetic, stores, illegal, HALT ----------------
    clear_mem();
    put(16'h0A, 16'h4105);  // ADDI R1 = R0 + 5
    put(16'h0C, 16'h42FF);  // ADDI R2 = R0 + (-1)
    put(16'h0E, 16'h06C0);  // ADD  R3 = R1 + R2 = 4
    put(16'h10, 16'h6120);  // SW   R1 -> [0x20]
    put(16'h12, 16'h6322);  // SW   R3 -> [0x22]
    put(16'h14, 16'h0181);  // SUB  R2 = R0 - R1 = 0xFFFB
    put(16'h16, 16'h09C2);  // AND  R3 = R2 & R1 = 1
    put(16'h18, 16'h6224);  // SW   R2 -> [0x24]
    put(16'h1A, 16'h2FFF);  // opcode 0010: illegal NOP
    put(16'h1C, 16'h6326);  // SW   R3 -> [0x26]
    put(16'h1E, 16'hF000);  // HALT
    repeat (3) @(negedge Clock);
    chk("rst_pc", pc, 16'h000A);
    chk("rst_addr", mem_addr, 16'h000A);
    chk("rst_we", mem_we, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_opcode", opcode, 0);
    release_reset(base);
    @(negedge Clock);
    chk("fetch0_req", mem_req, 1);
    chk("fetch0_addr", mem_addr, 16'h000A);
    chk("fetch0_we", mem_we, 0);
    @(negedge Clock);
    chk("fetch0_pc", pc, 16'h000C);
    chk("fetch0_opcode", opcode, 4'h4);
    run_until_halt("p1", 300);
    chk("p1_count", acc_addr.size() - base, 15);
    chk_acc("p1_f0a", base, 0, 16'h0A, 0, 0);
    chk_acc("p1_f0c", base, 1, 16'h0C, 0, 0);
    chk_acc("p1_sw_r1", base, 4, 16'h20, 1, 16'h0005);
    chk_acc("p1_sw_add", base, 6, 16'h22, 1, 16'h0004);
    chk_acc("p1_sw_sub", base, 10, 16'h24, 1, 16'hFFFB);
    chk_acc("p1_sw_after_illegal", base, 13, 16'h26, 1, 16'h0001);
    chk_acc("p1_f1e", base, 14, 16'h1E, 0, 0);
    chk_gap("p1_addi_cycles", base, 0, 1, 4);
    chk_gap("p1_add_cycles", base, 2, 3, 4);
    chk_gap("p1_sw_to_mem", base, 3, 4, 3);
    chk_gap("p1_sw_cycles", base, 3, 5, 4);
    chk_gap("p1_illegal_cycles", base, 11, 12, 2);
    chk("p1_illegal_flag", illegal, 1);
    chk("p1_pc_after_halt", pc, 16'h0020);
    bad = 0;
    n = acc_addr.size();
    repeat (10) begin
      @(negedge Clock);
      if (mem_req !== 1'b0) bad++;
    end
    chk("p1_halt_req_low", bad, 0);
    chk("p1_halt_no_access", acc_addr.size(), n);
    chk("p1_halt_sticky", halted, 1);

    // ---------------- Program 2: LW/SW with 3 data wait cycles, OR ----------------
    enter_reset();
    clear_mem();
    put(16'h0A, 16'h5220);  // LW   R2 <- [0x20]
    put(16'h0C, 16'h6222);  // SW   R2 -> [0x22]
    put(16'h0E, 16'h4130);  // ADDI R1 = 0x30
    put(16'h10, 16'h06C3);  // OR   R3 = R1 | R2 = 0x35
    put(16'h12, 16'h6324);  // SW   R3 -> [0x24]
    put(16'h14, 16'hF000);  // HALT
    put(16'h20, 16'h0005);
    data_wait = 3;
    release_reset(base);
    run_until_halt("p2", 300);
    chk("p2_illegal_cleared", illegal, 0);
    chk("p2_count", acc_addr.size() - base, 9);
    chk_acc("p2_lw_read", base, 1, 16'h20, 0, 0);
    chk_acc("p2_sw_loaded", base, 3, 16'h22, 1, 16'h0005);
    chk_acc("p2_sw_or", base, 7, 16'h24, 1, 16'h0035);
    chk_gap("p2_lw_cycles", base, 0, 2, 8);
    chk_gap("p2_lw_to_done", base, 0, 1, 6);
    chk_gap("p2_sw_cycles", base, 2, 4, 7);
    data_wait = 0;

    // ---------------- Program 3: branches ----------------
    enter_reset();
    clear_mem();
    put(16'h0A, 16'h7012);  // BEQ R0,R0 -> 0x30
    put(16'h30, 16'h75FE);  // BEQ R1,R1, -2 -> 0x2E
    put(16'h2E, 16'h7008);  // BEQ R0,R0 -> 0x40
    put(16'h40, 16'h85FE);  // BNE R1,R1 not taken -> 0x42
    put(16'h42, 16'h4101);  // ADDI R1 = 1
    put(16'h44, 16'h8102);  // BNE R0,R1 taken -> 0x4A
    put(16'h46, 16'h0000);
    put(16'h4A, 16'hF000);  // HALT
    release_reset(base);
    run_until_halt("p3", 300);
    chk("p3_count", acc_addr.size() - base, 7);
    chk_acc("p3_beq_fwd", base, 1, 16'h30, 0, 0);
    chk_acc("p3_beq_back", base, 2, 16'h2E, 0, 0);
    chk_acc("p3_beq_far", base, 3, 16'h40, 0, 0);
    chk_acc("p3_bne_not_taken", base, 4, 16'h42, 0, 0);
    chk_acc("p3_bne_taken", base, 6, 16'h4A, 0, 0);
    chk_gap("p3_beq_cycles", base, 0, 1, 3);
    chk_gap("p3_bne_cycles", base, 3, 4, 3);
    chk("p3_illegal", illegal, 0);

    // ---------------- Program 4: opcode 1001 ----------------
    enter_reset();
    clear_mem();
    put(16'h0A, 16'h9040);  // J 0x040
    release_reset(base);
    run_until_halt("p4", 100);
`ifdef MCDP_JUMP_EN
    chk("p4_count", acc_addr.size() - base, 2);
    chk_acc("p4_jump", base, 1, 16'h80, 0, 0);
    chk_gap("p4_jump_cycles", base, 0, 1, 3);
    chk("p4_illegal", illegal, 0);
`else
    chk("p4_count", acc_addr.size() - base, 2);
    chk_acc("p4_j_as_nop", base, 1, 16'h0C, 0, 0);
    chk_gap("p4_j_nop_cycles", base, 0, 1, 2);
    chk("p4_illegal", illegal, 1);
`endif

    // ---------------- Program 5: reset during a stalled LW ----------------
    enter_reset();
    clear_mem();
    put(16'h0A, 16'h5220);  // LW R2 <- [0x20]
    put(16'h0C, 16'hF000);  // HALT
    put(16'h20, 16'h1234);
    data_wait = 50;
    release_reset(base);
    n = 0;
    while (!(mem_req === 1'b1 && mem_addr == 16'h0020) && n < 40) begin
      @(negedge Clock);
      n++;
    end
    chk("p5_lw_reached", mem_req === 1'b1 && mem_addr == 16'h0020, 1);
    repeat (3) @(negedge Clock);
    chk("p5_stalled_req", mem_req, 1);
    chk("p5_stalled_addr", mem_addr, 16'h0020);
    Resetn = 1'b0;
    @(negedge Clock);
    chk("p5_req_dropped", mem_req, 0);
    chk("p5_pc_reset", pc, 16'h000A);
    data_wait = 0;
    @(negedge Clock);
    release_reset(base);
    run_until_halt("p5", 100);
    chk("p5_count", acc_addr.size() - base, 3);
    chk_acc("p5_refetch", base, 0, 16'h0A, 0, 0);
    chk_acc("p5_lw_retry", base, 1, 16'h20, 0, 0);
    chk_acc("p5_halt_fetch", base, 2, 16'h0C, 0, 0);

    chk("req_stability", stab_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
